fwd_hazard_ctrl: RTL

- Control end of the pipeline operand-forwarding path: tracks destination-register tags for the EX, MEM and WB stages.
- Produces the 2-bit select codes consumed by the 3-input operand muxes in EX.
- Generates load-use stalls and branch flushes for the 5-stage RV32I pipeline. It sits beside the pipeline registers and receives decode-stage fields each cycle.

---
 rtl/fwd_hazard_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and hazard control for a 5-stage RV32I pipeline.
// Tracks EX/MEM/WB destination tags and produces mux selects, stalls and flushes.
module fwd_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd,
   input  logic                      id_regwrite,
   input  logic                      id_is_load,
   input  logic                      ex_pc_src,
   input  logic                      ext_stall,
   output logic [1:0]                fwd_a_sel,
   output logic [1:0]                fwd_b_sel,
   output logic                      stall_f,
   output logic                      stall_d,
   output logic                      flush_d,
   output logic                      flush_e,
   output logic [CNT_WIDTH-1:0]      stall_cycles
);

   localparam logic [REG_ADDR_WIDTH-1:0] REG_X0  = {REG_ADDR_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0]      CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0]      CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                      ex_valid_r;
   logic [REG_ADDR_WIDTH-1:0] ex_rs1_r;
   logic [REG_ADDR_WIDTH-1:0] ex_rs2_r;
   logic [REG_ADDR_WIDTH-1:0] ex_rd_r;
   logic                      ex_regwrite_r;
   logic                      ex_is_load_r;
   logic                      mem_valid_r;
   logic [REG_ADDR_WIDTH-1:0] mem_rd_r;
   logic                      mem_regwrite_r;
   logic                      wb_valid_r;
   logic [REG_ADDR_WIDTH-1:0] wb_rd_r;
   logic                      wb_regwrite_r;

   logic load_use_s;
   logic a_mem_hit_s;
   logic a_wb_hit_s;
   logic b_mem_hit_s;
   logic b_wb_hit_s;

   // MEM beats WB; an operand that is x0 or an empty EX slot never forwards.
   function automatic logic [1:0] fwd_pick(input logic use_ok, input logic mem_hit,
                                           input logic wb_hit);
      logic [1:0] sel;
      if (use_ok && mem_hit) begin
         sel = 2'b10;
      end else if (use_ok && wb_hit) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Tag matches against the older records and forwarding selects.
   always_comb begin
      a_mem_hit_s = mem_valid_r && mem_regwrite_r && (mem_rd_r == ex_rs1_r);
      a_wb_hit_s  = wb_valid_r  && wb_regwrite_r  && (wb_rd_r  == ex_rs1_r);
      b_mem_hit_s = mem_valid_r && mem_regwrite_r && (mem_rd_r == ex_rs2_r);
      b_wb_hit_s  = wb_valid_r  && wb_regwrite_r  && (wb_rd_r  == ex_rs2_r);
      fwd_a_sel   = fwd_pick(ex_valid_r && (ex_rs1_r != REG_X0), a_mem_hit_s, a_wb_hit_s);
      fwd_b_sel   = fwd_pick(ex_valid_r && (ex_rs2_r != REG_X0), b_mem_hit_s, b_wb_hit_s);
   end

   // Load-use detection and prioritised stall/flush generation.
   always_comb begin
      load_use_s = id_valid && ex_valid_r && ex_is_load_r && (ex_rd_r != REG_X0) &&
                   ((ex_rd_r == id_rs1) || (ex_rd_r == id_rs2));
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      // rst_n gates controls so an external freeze cannot leak out during reset.
      if (!rst_n) begin
         stall_f = 1'b0;
      end else if (ext_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
      end else if (ex_pc_src) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if (load_use_s) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end else begin
         stall_f = 1'b0;
      end
   end

   // Stage records advance together unless the pipeline is frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_r     <= 1'b0;
         ex_rs1_r       <= REG_X0;
         ex_rs2_r       <= REG_X0;
         ex_rd_r        <= REG_X0;
         ex_regwrite_r  <= 1'b0;
         ex_is_load_r   <= 1'b0;
         mem_valid_r    <= 1'b0;
         mem_rd_r       <= REG_X0;
         mem_regwrite_r <= 1'b0;
         wb_valid_r     <= 1'b0;
         wb_rd_r        <= REG_X0;
         wb_regwrite_r  <= 1'b0;
      end else if (!ext_stall) begin
         wb_valid_r     <= mem_valid_r;
         wb_rd_r        <= mem_rd_r;
         wb_regwrite_r  <= mem_regwrite_r;
         mem_valid_r    <= ex_valid_r;
         mem_rd_r       <= ex_rd_r;
         mem_regwrite_r <= ex_regwrite_r;
         ex_valid_r     <= id_valid && !flush_e;
         ex_rs1_r       <= id_rs1;
         ex_rs2_r       <= id_rs2;
         ex_rd_r        <= id_rd;
         ex_regwrite_r  <= id_regwrite;
         ex_is_load_r   <= id_is_load;
      end else begin
         ex_valid_r     <= ex_valid_r;
      end
   end

   // Saturating count of decode-stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= {CNT_WIDTH{1'b0}};
      end else if (stall_d && (stall_cycles != CNT_MAX)) begin
         stall_cycles <= stall_cycles + CNT_ONE;
      end else begin
         stall_cycles <= stall_cycles;
      end
   end

endmodule
